// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage F/D/E/M/W pipeline.
// Shadows destination info for E/M/W and drives stall, flush and E-operand forwarding selects.
module hazard_unit #(
  parameter int NUM_REGS      = 4,
  parameter int ADDRESS_WIDTH = $clog2(NUM_REGS),
  parameter int FWD_EN        = 1,
  parameter int R0_ZERO       = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_validD,
  input  logic [ADDRESS_WIDTH-1:0] i_rs1D,
  input  logic [ADDRESS_WIDTH-1:0] i_rs2D,
  input  logic                     i_use_rs1D,
  input  logic                     i_use_rs2D,
  input  logic [ADDRESS_WIDTH-1:0] i_rdD,
  input  logic                     i_regWriteD,
  input  logic                     i_memReadD,
  input  logic                     i_branch_takenE,
  input  logic                     i_ex_busyE,
  output logic                     o_stallF,
  output logic                     o_stallD,
  output logic                     o_stallE,
  output logic                     o_flushD,
  output logic                     o_flushE,
  output logic [1:0]               o_fwdAE,
  output logic [1:0]               o_fwdBE,
  output logic [CNT_WIDTH-1:0]     o_stall_cnt,
  output logic [CNT_WIDTH-1:0]     o_flush_cnt
);

  // Shadow stages: _p0 = E, _p1 = M, _p2 = W
  logic                     vld_p0, vld_p1, vld_p2;
  logic [ADDRESS_WIDTH-1:0] rd_p0, rd_p1, rd_p2;
  logic                     rw_p0, rw_p1, rw_p2;
  logic                     mr_p0, mr_p1;
  logic [ADDRESS_WIDTH-1:0] rs1_p0, rs2_p0;
  logic                     u1_p0, u2_p0;

  logic hazard;
  logic hit_e1, hit_e2, hit_m1, hit_m2;

  function automatic logic match(input logic vld, input logic rw, input logic use_src,
                                 input logic [ADDRESS_WIDTH-1:0] rd,
                                 input logic [ADDRESS_WIDTH-1:0] src);
    return vld & rw & use_src & (rd == src) & ~((R0_ZERO != 0) & (rd == '0));
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic en);
    if (en && (cnt != '1)) return cnt + CNT_WIDTH'(1);
    return cnt;
  endfunction

  // Operand select: an M-stage load never forwards; its data arrives from W.
  function automatic logic [1:0] fwd_sel(input logic use_src,
                                         input logic [ADDRESS_WIDTH-1:0] src);
    if (FWD_EN == 0) return 2'b00;
    if (match(vld_p1, rw_p1, use_src, rd_p1, src) && !mr_p1) return 2'b10;
    if (match(vld_p2, rw_p2, use_src, rd_p2, src)) return 2'b01;
    return 2'b00;
  endfunction

  // D-stage hazard detection against E and M
  always_comb begin
    hit_e1 = match(vld_p0, rw_p0, i_use_rs1D, rd_p0, i_rs1D);
    hit_e2 = match(vld_p0, rw_p0, i_use_rs2D, rd_p0, i_rs2D);
    hit_m1 = match(vld_p1, rw_p1, i_use_rs1D, rd_p1, i_rs1D);
    hit_m2 = match(vld_p1, rw_p1, i_use_rs2D, rd_p1, i_rs2D);
    if (FWD_EN != 0) hazard = i_validD & (hit_e1 | hit_e2) & mr_p0;
    else             hazard = i_validD & (hit_e1 | hit_e2 | hit_m1 | hit_m2);
  end

  always_comb begin
    o_stallF = 1'b0;
    o_stallD = 1'b0;
    o_stallE = 1'b0;
    o_flushD = 1'b0;
    o_flushE = 1'b0;
    if (i_ex_busyE) begin
      o_stallF = 1'b1;
      o_stallD = 1'b1;
      o_stallE = 1'b1;
    end else if (i_branch_takenE) begin
      o_flushD = 1'b1;
      o_flushE = 1'b1;
    end else if (hazard) begin
      o_stallF = 1'b1;
      o_stallD = 1'b1;
      o_flushE = 1'b1;
    end
  end

  // A bubble in E reads nothing, so its stale source fields are masked by valid.
  always_comb begin
    o_fwdAE = fwd_sel(vld_p0 & u1_p0, rs1_p0);
    o_fwdBE = fwd_sel(vld_p0 & u2_p0, rs2_p0);
  end

  // Shadow data: qualified by the valids, so left unreset
  always_ff @(posedge i_clk) begin
    rd_p2 <= rd_p1;
    rw_p2 <= rw_p1;
    if (!i_ex_busyE) begin
      rd_p1  <= rd_p0;
      rw_p1  <= rw_p0;
      mr_p1  <= mr_p0;
      rd_p0  <= i_rdD;
      rw_p0  <= i_regWriteD;
      mr_p0  <= i_memReadD;
      rs1_p0 <= i_rs1D;
      rs2_p0 <= i_rs2D;
      u1_p0  <= i_use_rs1D;
      u2_p0  <= i_use_rs2D;
    end
  end

  // Shadow valids and performance counters
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (i_ex_busyE) begin
        vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        vld_p0 <= i_validD & ~o_flushE;
      end
      o_stall_cnt <= sat_inc(o_stall_cnt, o_stallD);
      o_flush_cnt <= sat_inc(o_flush_cnt, i_branch_takenE & ~i_ex_busyE);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a forwarding instance and a stall-only/r0-zero/2-bit-counter instance
// driven in lockstep and checked against a list-of-instructions pipeline model.
module tb_hazard_unit;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          vD, u1D, u2D, rwD, mrD, br, busy;
  logic [AW-1:0] rs1D, rs2D, rdD;

  logic       a_sF, a_sD, a_sE, a_fD, a_fE, b_sF, b_sD, b_sE, b_fD, b_fE;
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic [15:0] a_sc, a_fc;
  logic [1:0]  b_sc, b_fc;

  hazard_unit #(.NUM_REGS(4), .FWD_EN(1), .R0_ZERO(0), .CNT_WIDTH(16)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_validD(vD), .i_rs1D(rs1D), .i_rs2D(rs2D),
    .i_use_rs1D(u1D), .i_use_rs2D(u2D), .i_rdD(rdD), .i_regWriteD(rwD), .i_memReadD(mrD),
    .i_branch_takenE(br), .i_ex_busyE(busy),
    .o_stallF(a_sF), .o_stallD(a_sD), .o_stallE(a_sE), .o_flushD(a_fD), .o_flushE(a_fE),
    .o_fwdAE(a_fa), .o_fwdBE(a_fb), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc));

  hazard_unit #(.NUM_REGS(4), .FWD_EN(0), .R0_ZERO(1), .CNT_WIDTH(2)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_validD(vD), .i_rs1D(rs1D), .i_rs2D(rs2D),
    .i_use_rs1D(u1D), .i_use_rs2D(u2D), .i_rdD(rdD), .i_regWriteD(rwD), .i_memReadD(mrD),
    .i_branch_takenE(br), .i_ex_busyE(busy),
    .o_stallF(b_sF), .o_stallD(b_sD), .o_stallE(b_sE), .o_flushD(b_fD), .o_flushE(b_fE),
    .o_fwdAE(b_fa), .o_fwdBE(b_fb), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc));

  typedef struct {
    bit v; int rd; bit rw; bit mr; int rs1; int rs2; bit u1; bit u2;
  } ent_t;

  // Reference: per instance, the instructions occupying E (0), M (1), W (2)
  ent_t pipe [2][3];
  int   scnt [2];
  int   fcnt [2];
  bit   FWD  [2] = '{1'b1, 1'b0};
  bit   R0Z  [2] = '{1'b0, 1'b1};
  int   CMAX [2] = '{65535, 3};

  logic [4:0]  smp_ctl [2];
  logic [1:0]  smp_fa  [2];
  logic [1:0]  smp_fb  [2];
  logic [31:0] smp_sc  [2];
  logic [31:0] smp_fc  [2];

  int ncmp = 0;
  int nfail = 0;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(int k, int s, int r);
    return pipe[k][s].v && pipe[k][s].rw && pipe[k][s].rd == r && !(R0Z[k] && r == 0);
  endfunction

  function automatic int fwd_of(int k, int r, bit used);
    if (!FWD[k] || !used) return 0;
    if (writes(k, 1, r) && !pipe[k][1].mr) return 2;
    if (writes(k, 2, r)) return 1;
    return 0;
  endfunction

  function automatic int sat(int k, int v);
    return (v > CMAX[k]) ? CMAX[k] : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = '{default: 0};
      scnt[k] = 0;
      fcnt[k] = 0;
    end
  endtask

  task automatic setD(input bit v, input int r1, input bit q1, input int r2, input bit q2,
                      input int rd, input bit rw, input bit mr, input bit b, input bit bz);
    vD = v; rs1D = AW'(r1); u1D = q1; rs2D = AW'(r2); u2D = q2;
    rdD = AW'(rd); rwD = rw; mrD = mr; br = b; busy = bz;
  endtask

  // One clock: sample and check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit   needs, haz [2];
    logic [4:0] exp_ctl [2];
    @(negedge clk);
    smp_ctl[0] = {a_sF, a_sD, a_sE, a_fD, a_fE};
    smp_ctl[1] = {b_sF, b_sD, b_sE, b_fD, b_fE};
    smp_fa[0] = a_fa; smp_fb[0] = a_fb; smp_sc[0] = 32'(a_sc); smp_fc[0] = 32'(a_fc);
    smp_fa[1] = b_fa; smp_fb[1] = b_fb; smp_sc[1] = 32'(b_sc); smp_fc[1] = 32'(b_fc);
    for (int k = 0; k < 2; k++) begin
      needs = 0;
      for (int s = 0; s < (FWD[k] ? 1 : 2); s++)
        if ((u1D && writes(k, s, rs1D)) || (u2D && writes(k, s, rs2D)))
          if (!FWD[k] || pipe[k][0].mr) needs = 1;
      haz[k] = vD && needs;
      exp_ctl[k] = busy ? 5'b11100 : br ? 5'b00011 : haz[k] ? 5'b11001 : 5'b00000;
      chk($sformatf("ctl[%0d]", k), 32'(smp_ctl[k]), 32'(exp_ctl[k]));
      if (!busy) begin
        chk($sformatf("fwdA[%0d]", k), 32'(smp_fa[k]), fwd_of(k, pipe[k][0].rs1, pipe[k][0].u1));
        chk($sformatf("fwdB[%0d]", k), 32'(smp_fb[k]), fwd_of(k, pipe[k][0].rs2, pipe[k][0].u2));
      end
      chk($sformatf("stall_cnt[%0d]", k), smp_sc[k], scnt[k]);
      chk($sformatf("flush_cnt[%0d]", k), smp_fc[k], fcnt[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      scnt[k] = sat(k, scnt[k] + int'(exp_ctl[k][3]));
      fcnt[k] = sat(k, fcnt[k] + int'(br && !busy));
      pipe[k][2] = pipe[k][1];
      if (busy) begin
        pipe[k][1] = '{default: 0};
      end else begin
        pipe[k][1] = pipe[k][0];
        if (exp_ctl[k][0] || !vD) pipe[k][0] = '{default: 0};
        else pipe[k][0] = '{v: 1, rd: rdD, rw: rwD, mr: mrD, rs1: rs1D, rs2: rs2D, u1: u1D, u2: u2D};
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    setD(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    setD(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Post-reset: empty pipeline, zero counters
    idle(1);
    chk("rst_ctl", 32'(smp_ctl[0]), 0);
    chk("rst_cnt", smp_sc[0], 0);

    // ALU chain: M forward then W forward
    idle(2);
    setD(1, 2, 1, 3, 1, 1, 1, 0, 0, 0); cycle();
    setD(1, 1, 1, 3, 1, 2, 1, 0, 0, 0); cycle();
    chk("alu_nostall", 32'(smp_ctl[0]), 0);
    setD(1, 1, 1, 0, 0, 3, 1, 0, 0, 0); cycle();
    chk("alu_fwdM", 32'(smp_fa[0]), 2);
    idle(1);
    chk("alu_fwdW", 32'(smp_fa[0]), 1);

    // Load-use: one stall cycle, then W forward
    idle(3);
    setD(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); cycle();
    base = scnt[0];
    setD(1, 3, 0, 2, 1, 3, 1, 0, 0, 0); cycle();
    chk("lu_stall", 32'(smp_ctl[0]), 32'b11001);
    cycle();
    chk("lu_release", 32'(smp_ctl[0]), 0);
    idle(1);
    chk("lu_fwdB", 32'(smp_fb[0]), 1);
    chk("lu_cnt", smp_sc[0], base + 1);

    // Branch coinciding with load-use: flush wins
    idle(3);
    setD(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); cycle();
    base = fcnt[0];
    setD(1, 3, 1, 0, 0, 1, 1, 0, 1, 0); cycle();
    chk("br_ctl", 32'(smp_ctl[0]), 32'b00011);
    idle(2);
    chk("br_cnt", smp_fc[0], base + 1);

    // Multi-cycle E: three busy cycles, branch ignored
    idle(3);
    setD(1, 2, 1, 3, 1, 1, 1, 0, 0, 0); cycle();
    base = scnt[0];
    setD(1, 1, 1, 0, 0, 2, 1, 0, 0, 1); cycle();
    chk("busy1", 32'(smp_ctl[0]), 32'b11100);
    setD(1, 1, 1, 0, 0, 2, 1, 0, 1, 1); cycle();
    chk("busy_br", 32'(smp_ctl[0]), 32'b11100);
    setD(1, 1, 1, 0, 0, 2, 1, 0, 0, 1); cycle();
    setD(1, 1, 1, 0, 0, 2, 1, 0, 0, 0); cycle();
    chk("busy_cnt", smp_sc[0], base + 3);
    idle(1);
    chk("busy_heldE", 32'(smp_fa[0]), 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      setD($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 1), 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if (rwD) mrD = $urandom_range(0, 2) == 0;
      cycle();
    end

    // Asynchronous reset mid-cycle with a pending write to r1 in E
    idle(1);
    setD(1, 2, 1, 3, 1, 1, 1, 0, 0, 0); cycle();
    setD(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctlA", 32'({a_sF, a_sD, a_sE, a_fD, a_fE}), 0);
    chk("arst_ctlB", 32'({b_sF, b_sD, b_sE, b_fD, b_fE}), 0);
    chk("arst_fwd", 32'({a_fa, a_fb}), 0);
    chk("arst_cnt", 32'({a_sc, a_fc, b_sc, b_fc}), 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Stall-only instance: RAW on r1 stalls twice, r0 never, counter saturates
    setD(1, 2, 1, 3, 1, 1, 1, 0, 0, 0); cycle();
    chk("so_first", 32'(smp_ctl[1]), 0);
    setD(1, 1, 1, 0, 0, 2, 1, 0, 0, 0); cycle();
    chk("so_stallE", 32'(smp_ctl[1]), 32'b11001);
    cycle();
    chk("so_stallM", 32'(smp_ctl[1]), 32'b11001);
    cycle();
    chk("so_go", 32'(smp_ctl[1]), 0);
    chk("so_cnt2", smp_sc[1], 2);
    setD(1, 3, 1, 3, 1, 0, 1, 0, 0, 0); cycle();
    setD(1, 0, 1, 0, 1, 3, 1, 0, 0, 0); cycle();
    chk("so_r0", 32'(smp_ctl[1]), 0);
    setD(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle();
    idle(1);
    chk("so_sat", smp_sc[1], 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
